// File: rtl/gate_response_checker_if.sv
// gate_response_checker_if: stimulus, observed-output and result signals of a gate response checker
interface gate_response_checker_if #(
    parameter int W = 2,
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] vec_total;
    logic             vec_valid;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [W-1:0]     y_obs;
    logic             busy;
    logic             done;
    logic             all_pass;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic             fail_seen;
    logic [CNT_W-1:0] first_fail_idx;
    logic [W-1:0]     first_fail_exp;
    logic [W-1:0]     first_fail_obs;

    modport master (
        output start, vec_total, vec_valid, a, b, y_obs,
        input  busy, done, all_pass, pass_cnt, fail_cnt, fail_seen,
               first_fail_idx, first_fail_exp, first_fail_obs
    );

    modport slave (
        input  start, vec_total, vec_valid, a, b, y_obs,
        output busy, done, all_pass, pass_cnt, fail_cnt, fail_seen,
               first_fail_idx, first_fail_exp, first_fail_obs
    );
endinterface

// File: rtl/gate_response_checker.sv
// gate_response_checker: predicts a two-input gate's output, delays it by the DUT latency and scores y_obs
module gate_response_checker #(
    parameter int W = 2,
    parameter int OP = 0,
    parameter int LATENCY = 1,
    parameter int CNT_W = 8
) (
    input logic clk,
    input logic rst,
    gate_response_checker_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] total;
    logic [CNT_W-1:0] issued;
    logic [CNT_W-1:0] checked;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic [CNT_W-1:0] ff_idx;
    logic             fail_seen;
    logic [W-1:0]     ff_exp;
    logic [W-1:0]     ff_obs;
    logic [W-1:0]     exp;
    logic [LATENCY-1:0] dv;
    logic [W-1:0]     de [LATENCY];
    logic [CNT_W-1:0] di [LATENCY];
    logic             accept;
    logic             cmp;
    logic             match;

    // illegal OP values predict all-zero so every vector is visibly checked against a fixed value
    assign exp = OP == 0 ? bus.a & bus.b :
                 OP == 1 ? bus.a | bus.b :
                 OP == 2 ? bus.a ^ bus.b :
                 OP == 3 ? ~(bus.a & bus.b) :
                 OP == 4 ? ~(bus.a | bus.b) :
                 OP == 5 ? ~(bus.a ^ bus.b) : '0;

    assign accept = state == RUN && bus.vec_valid && issued < total;
    assign cmp    = state == RUN && dv[LATENCY-1];
    assign match  = bus.y_obs == de[LATENCY-1];

    always_ff @(posedge clk) begin
        de[0] <= exp;
        di[0] <= issued;
        for (int i = 1; i < LATENCY; i++) begin
            de[i] <= de[i-1];
            di[i] <= di[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            total     <= '0;
            issued    <= '0;
            checked   <= '0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            fail_seen <= 1'b0;
            ff_idx    <= '0;
            ff_exp    <= '0;
            ff_obs    <= '0;
            dv        <= '0;
        end else if (state != RUN && bus.start) begin
            state     <= RUN;
            total     <= bus.vec_total;
            issued    <= '0;
            checked   <= '0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            fail_seen <= 1'b0;
            ff_idx    <= '0;
            ff_exp    <= '0;
            ff_obs    <= '0;
            dv        <= '0;
        end else if (state == RUN) begin
            if (checked == total) state <= DONE;
            dv[0] <= accept;
            for (int i = 1; i < LATENCY; i++) dv[i] <= dv[i-1];
            if (accept) issued <= issued + CNT_W'(1);
            if (cmp) begin
                checked <= checked + CNT_W'(1);
                if (match && ~&pass_cnt) pass_cnt <= pass_cnt + CNT_W'(1);
                if (!match && ~&fail_cnt) fail_cnt <= fail_cnt + CNT_W'(1);
                if (!match && !fail_seen) begin
                    fail_seen <= 1'b1;
                    ff_idx    <= di[LATENCY-1];
                    ff_exp    <= de[LATENCY-1];
                    ff_obs    <= bus.y_obs;
                end
            end
        end
    end

    assign bus.busy           = state == RUN;
    assign bus.done           = state == DONE;
    assign bus.all_pass       = state == DONE && fail_cnt == '0;
    assign bus.pass_cnt       = pass_cnt;
    assign bus.fail_cnt       = fail_cnt;
    assign bus.fail_seen      = fail_seen;
    assign bus.first_fail_idx = ff_idx;
    assign bus.first_fail_exp = ff_exp;
    assign bus.first_fail_obs = ff_obs;
endmodule
